axi_wr_xbar: RTL and testbench

Registered, arbitrated AXI write crossbar between `NUM_M` masters and `NUM_S` slaves. It replaces the purely combinational write mux, and it decodes addresses itself. Each slave port has its own round-robin arbiter and its own transaction FSM, which holds the AW→W→B path of one write until the response handshake completes. Unmapped addresses go to an internal default slave that returns DECERR. The block sits inside the AXI top, next to the read crossbar.

---
 rtl/axi_xbar_pkg.sv | 27 ++
 rtl/axi_wr_xbar_if.sv | 38 +++
 rtl/axi_wr_xbar_arb.sv | 29 ++
 rtl/axi_wr_xbar.sv | 184 ++++++++++++++++++
 tb/tb_axi_wr_xbar.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_xbar_pkg.sv
// axi_xbar_pkg: shared widths, write-path FSM states, response codes and the
// default slave address map for the AXI write crossbar.
package axi_xbar_pkg;

  localparam int AXI_ID_W = 4;
  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 8;
  localparam int SIZE_W   = 3;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, AW, W, B} wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DEF_NUM_S = 6;

  // Element 0 is the rightmost entry.
  localparam logic [DEF_NUM_S-1:0][31:0] DEF_S_BASE = {
    32'h2000_0000, 32'h1001_0000, 32'h1002_0000,
    32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [DEF_NUM_S-1:0][31:0] DEF_S_MASK = {
    32'hFE00_0000, 32'hFFFF_FC00, 32'hFFFF_FC00,
    32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_C000};

endpackage

// File: rtl/axi_wr_xbar_if.sv
// axi_wr_xbar_if: bundle of N AXI write channels (AW, W, B).
//   master modport: drives AW/W payload+valid and BREADY.
//   slave modport : drives AWREADY, WREADY and the B channel.
// IDW is the AWID/BID width (narrow on the master side, widened on slaves).
interface axi_wr_xbar_if
  import axi_xbar_pkg::*;
#(
  parameter int N   = 1,
  parameter int IDW = AXI_ID_W
) ();
  logic [N-1:0][IDW-1:0]    AWID;
  logic [N-1:0][ADDR_W-1:0] AWADDR;
  logic [N-1:0][LEN_W-1:0]  AWLEN;
  logic [N-1:0][SIZE_W-1:0] AWSIZE;
  logic [N-1:0][1:0]        AWBURST;
  logic [N-1:0]             AWVALID;
  logic [N-1:0]             AWREADY;
  logic [N-1:0][DATA_W-1:0] WDATA;
  logic [N-1:0][STRB_W-1:0] WSTRB;
  logic [N-1:0]             WLAST;
  logic [N-1:0]             WVALID;
  logic [N-1:0]             WREADY;
  logic [N-1:0][IDW-1:0]    BID;
  logic [N-1:0][1:0]        BRESP;
  logic [N-1:0]             BVALID;
  logic [N-1:0]             BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );
  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/axi_wr_xbar_arb.sv
// rr_arbiter: combinational round-robin pick.
//   req       : request vector
//   ptr       : last winner; search starts at ptr+1 mod N
//   gnt_idx   : chosen requester (0 when none)
//   gnt_valid : any request present
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);
  int idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/axi_wr_xbar.sv
// axi_wr_xbar: arbitrated AXI write crossbar, NUM_M masters x NUM_S slaves.
//   ACLK / ARESET : clock, async active-high reset
//   m_if          : master-facing channels (crossbar acts as slave)
//   s_if          : slave-facing channels (crossbar acts as master)
// Each slave (plus an internal DECERR default slave at index NUM_S) owns a
// round-robin arbiter and an IDLE->AW->W->B FSM that locks one master onto
// that slave until its B handshake. busy[] keeps a master on one slave.
module axi_wr_xbar
  import axi_xbar_pkg::*;
#(
  parameter int NUM_M = 3,
  parameter int NUM_S = DEF_NUM_S,
  parameter logic [NUM_S-1:0][31:0] S_BASE = DEF_S_BASE,
  parameter logic [NUM_S-1:0][31:0] S_MASK = DEF_S_MASK,
  parameter int MIDX_BITS = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  parameter int SIDX_BITS = $clog2(NUM_S + 1)
) (
  input  logic          ACLK,
  input  logic          ARESET,
  axi_wr_xbar_if.slave  m_if,
  axi_wr_xbar_if.master s_if
);
  localparam int AXI_IDS_W = AXI_ID_W + MIDX_BITS;

  logic [NUM_M-1:0][SIDX_BITS-1:0] dec;
  logic [NUM_M-1:0] busy_q, busy_d;

  // Per-slave contributions, merged below.
  logic [NUM_M-1:0]    busy_set [NUM_S+1];
  logic [NUM_M-1:0]    busy_clr [NUM_S+1];
  logic [NUM_M-1:0]    awrdy_c  [NUM_S+1];
  logic [NUM_M-1:0]    wrdy_c   [NUM_S+1];
  logic [NUM_M-1:0]    bsel_c   [NUM_S+1];
  logic                bvld_c   [NUM_S+1];
  logic [AXI_ID_W-1:0] bid_c    [NUM_S+1];
  logic [1:0]          bresp_c  [NUM_S+1];

  // Address decode: iterate downward so the lowest matching slave wins.
  always_comb begin
    dec = '0;
    for (int m = 0; m < NUM_M; m++) begin
      dec[m] = SIDX_BITS'(NUM_S);
      for (int s = NUM_S - 1; s >= 0; s--)
        if ((m_if.AWADDR[m] & S_MASK[s]) == S_BASE[s]) dec[m] = SIDX_BITS'(s);
    end
  end

  // A master is set by at most one grant and never set+cleared together.
  always_comb begin
    busy_d = busy_q;
    for (int s = 0; s <= NUM_S; s++) busy_d = (busy_d & ~busy_clr[s]) | busy_set[s];
  end

  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) busy_q <= '0;
    else        busy_q <= busy_d;

  for (genvar s = 0; s <= NUM_S; s++) begin : g_sl
    wr_state_e            state_q, state_d;
    logic [MIDX_BITS-1:0] owner_q, owner_d, ptr_q, ptr_d, gnt_idx;
    logic [NUM_M-1:0]     req, own_oh, set_l, clr_l;
    logic                 gnt_vld, aw_rdy, w_rdy, b_vld, aw_hs, w_hs, b_hs;
    logic [1:0]           b_resp;
    logic [AXI_ID_W-1:0]  b_id;

    always_comb begin
      req = '0;
      for (int m = 0; m < NUM_M; m++)
        req[m] = m_if.AWVALID[m] && (dec[m] == SIDX_BITS'(s)) && !busy_q[m];
    end

    rr_arbiter #(.N(NUM_M), .IW(MIDX_BITS)) u_arb (
      .req(req), .ptr(ptr_q), .gnt_idx(gnt_idx), .gnt_valid(gnt_vld)
    );

    assign own_oh = NUM_M'(1) << owner_q;
    assign aw_hs  = (state_q == AW) && m_if.AWVALID[owner_q] && aw_rdy;
    assign w_hs   = (state_q == W)  && m_if.WVALID[owner_q]  && w_rdy;
    assign b_hs   = (state_q == B)  && b_vld && m_if.BREADY[owner_q];

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      set_l   = '0;
      clr_l   = '0;
      case (state_q)
        IDLE: if (gnt_vld) begin
          owner_d = gnt_idx;
          set_l   = NUM_M'(1) << gnt_idx;
          state_d = AW;
        end
        AW: if (aw_hs) state_d = W;
        W:  if (w_hs && m_if.WLAST[owner_q]) state_d = B;
        B:  if (b_hs) begin
          clr_l   = own_oh;
          ptr_d   = owner_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q   <= MIDX_BITS'(NUM_M - 1);
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end

    assign busy_set[s] = set_l;
    assign busy_clr[s] = clr_l;
    assign awrdy_c[s]  = (state_q == AW && aw_rdy) ? own_oh : '0;
    assign wrdy_c[s]   = (state_q == W  && w_rdy)  ? own_oh : '0;
    assign bsel_c[s]   = (state_q == B)            ? own_oh : '0;
    assign bvld_c[s]   = b_vld;
    assign bid_c[s]    = b_id;
    assign bresp_c[s]  = b_resp;

    if (s < NUM_S) begin : g_real
      logic sel_aw, sel_w, sel_b;
      assign sel_aw = (state_q == AW);
      assign sel_w  = (state_q == W);
      assign sel_b  = (state_q == B);

      assign aw_rdy = s_if.AWREADY[s];
      assign w_rdy  = s_if.WREADY[s];
      assign b_vld  = s_if.BVALID[s];
      assign b_resp = s_if.BRESP[s];
      assign b_id   = s_if.BID[s][AXI_ID_W-1:0];

      // Owner index sits above the master ID so B can be steered back.
      assign s_if.AWVALID[s] = sel_aw && m_if.AWVALID[owner_q];
      assign s_if.AWID[s]    = sel_aw ? ((AXI_IDS_W'(owner_q) << AXI_ID_W)
                                         | AXI_IDS_W'(m_if.AWID[owner_q])) : '0;
      assign s_if.AWADDR[s]  = sel_aw ? (m_if.AWADDR[owner_q] - S_BASE[s]) : '0;
      assign s_if.AWLEN[s]   = sel_aw ? m_if.AWLEN[owner_q]   : '0;
      assign s_if.AWSIZE[s]  = sel_aw ? m_if.AWSIZE[owner_q]  : '0;
      assign s_if.AWBURST[s] = sel_aw ? m_if.AWBURST[owner_q] : '0;
      assign s_if.WVALID[s]  = sel_w && m_if.WVALID[owner_q];
      assign s_if.WDATA[s]   = sel_w ? m_if.WDATA[owner_q] : '0;
      assign s_if.WSTRB[s]   = sel_w ? m_if.WSTRB[owner_q] : '0;
      assign s_if.WLAST[s]   = sel_w && m_if.WLAST[owner_q];
      assign s_if.BREADY[s]  = sel_b && m_if.BREADY[owner_q];
    end else begin : g_dflt
      // Default slave: accept everything, drop data, answer DECERR.
      logic [AXI_ID_W-1:0] bid_q, bid_d;
      assign aw_rdy = (state_q == AW);
      assign w_rdy  = (state_q == W);
      assign b_vld  = (state_q == B);
      assign b_resp = RESP_DECERR;
      assign b_id   = bid_q;
      assign bid_d  = aw_hs ? m_if.AWID[owner_q] : bid_q;

      always_ff @(posedge ACLK or posedge ARESET)
        if (ARESET) bid_q <= '0;
        else        bid_q <= bid_d;
    end
  end

  // Master side: OR of every slave currently owned by that master.
  always_comb begin
    m_if.AWREADY = '0;
    m_if.WREADY  = '0;
    m_if.BVALID  = '0;
    m_if.BID     = '0;
    m_if.BRESP   = '0;
    for (int s = 0; s <= NUM_S; s++) begin
      m_if.AWREADY |= awrdy_c[s];
      m_if.WREADY  |= wrdy_c[s];
      for (int m = 0; m < NUM_M; m++)
        if (bsel_c[s][m]) begin
          m_if.BVALID[m] |= bvld_c[s];
          m_if.BID[m]    |= bid_c[s];
          m_if.BRESP[m]  |= bresp_c[s];
        end
    end
  end

endmodule

// File: tb/tb_axi_wr_xbar.sv
// tb_axi_wr_xbar: directed checks of the AXI write crossbar. Inputs change
// 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_axi_wr_xbar;
  import axi_xbar_pkg::*;

  localparam int NM  = 3;
  localparam int NS  = 6;
  localparam int IDS = AXI_ID_W + 2;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  axi_wr_xbar_if #(.N(NM), .IDW(AXI_ID_W)) m_bus ();
  axi_wr_xbar_if #(.N(NS), .IDW(IDS))      s_bus ();

  axi_wr_xbar #(.NUM_M(NM), .NUM_S(NS)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .m_if(m_bus.slave), .s_if(s_bus.master)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m_bus.AWVALID = '0; m_bus.AWID = '0; m_bus.AWADDR = '0; m_bus.AWLEN = '0;
    m_bus.AWSIZE = '0; m_bus.AWBURST = '0;
    m_bus.WVALID = '0; m_bus.WDATA = '0; m_bus.WSTRB = '0; m_bus.WLAST = '0;
    m_bus.BREADY = '1;
    s_bus.AWREADY = '1; s_bus.WREADY = '1;
    s_bus.BVALID = '0; s_bus.BID = '0; s_bus.BRESP = '0;
  endtask

  task automatic aw(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    m_bus.AWVALID[m] = 1'b1; m_bus.AWID[m] = id; m_bus.AWADDR[m] = addr;
    m_bus.AWLEN[m] = len; m_bus.AWSIZE[m] = 3'd2; m_bus.AWBURST[m] = 2'b01;
  endtask

  task automatic wbeat(input int m, input logic [31:0] d, input logic last);
    m_bus.WVALID[m] = 1'b1; m_bus.WDATA[m] = d; m_bus.WSTRB[m] = 4'hF; m_bus.WLAST[m] = last;
  endtask

  task automatic sresp(input int s, input logic [IDS-1:0] id);
    s_bus.BVALID[s] = 1'b1; s_bus.BID[s] = id; s_bus.BRESP[s] = RESP_OKAY;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    idle_inputs();
    step();
    step();
    ARESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    ARESET = 1'b1;
    m_bus.AWVALID = 3'b001;  // must be ignored during reset
    m_bus.AWADDR[0] = 32'h0002_0000;
    step(); step();
    chk("rst_awready_m", m_bus.AWREADY, 0);
    chk("rst_wready_m",  m_bus.WREADY, 0);
    chk("rst_bvalid_m",  m_bus.BVALID, 0);
    chk("rst_awvalid_s", s_bus.AWVALID, 0);
    chk("rst_wvalid_s",  s_bus.WVALID, 0);
    chk("rst_bready_s",  s_bus.BREADY, 0);
    idle_inputs();
    ARESET = 1'b0;

    // M0 -> DM, 4 beats.
    aw(0, 4'h5, 32'h0002_0010, 8'd3);
    settle();
    chk("t1_idle_awvalid_s", s_bus.AWVALID, 0);
    chk("t1_idle_awready_m", m_bus.AWREADY, 0);
    step();
    chk("t1_awvalid_s", s_bus.AWVALID, 6'b000100);
    chk("t1_awaddr_s",  s_bus.AWADDR[2], 32'h10);
    chk("t1_awid_s",    s_bus.AWID[2], 6'h05);
    chk("t1_awlen_s",   s_bus.AWLEN[2], 3);
    chk("t1_awready_m", m_bus.AWREADY, 3'b001);
    step();
    m_bus.AWVALID[0] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wbeat(0, 32'hD000_0000 + b, b == 3);
      settle();
      chk("t1_wdata_s",   s_bus.WDATA[2], 32'hD000_0000 + b);
      chk("t1_wready_m",  m_bus.WREADY, 3'b001);
      step();
    end
    m_bus.WVALID = '0; m_bus.WLAST = '0;
    sresp(2, 6'h05);
    settle();
    chk("t1_bvalid_m", m_bus.BVALID, 3'b001);
    chk("t1_bid_m",    m_bus.BID[0], 4'h5);
    chk("t1_bresp_m",  m_bus.BRESP[0], RESP_OKAY);
    chk("t1_bready_s", s_bus.BREADY, 6'b000100);
    step();
    s_bus.BVALID = '0;
    settle();
    chk("t1_done_bvalid_m", m_bus.BVALID, 0);
    chk("t1_done_bready_s", s_bus.BREADY, 0);

    // M0 and M1 collide on DM after reset: M0 first, M1 after one IDLE cycle.
    do_reset();
    aw(0, 4'h1, 32'h0002_0100, 8'd0);
    aw(1, 4'h2, 32'h0002_0200, 8'd0);
    step();
    chk("t2_awready_m", m_bus.AWREADY, 3'b001);
    chk("t2_awid_s0",   s_bus.AWID[2], 6'h01);
    chk("t2_awaddr_s0", s_bus.AWADDR[2], 32'h100);
    step();
    m_bus.AWVALID[0] = 1'b0;
    wbeat(0, 32'h1111_0000, 1'b1);
    settle();
    chk("t2_wready_m0", m_bus.WREADY, 3'b001);
    step();
    m_bus.WVALID = '0;
    sresp(2, 6'h01);
    settle();
    chk("t2_bvalid_m0", m_bus.BVALID, 3'b001);
    chk("t2_bid_m0",    m_bus.BID[0], 4'h1);
    step();
    s_bus.BVALID = '0;
    settle();
    chk("t2_idle_gap", s_bus.AWVALID, 0);
    step();
    chk("t2_awvalid_s1", s_bus.AWVALID, 6'b000100);
    chk("t2_awid_s1",    s_bus.AWID[2], 6'h12);
    chk("t2_awaddr_s1",  s_bus.AWADDR[2], 32'h200);
    chk("t2_awready_m1", m_bus.AWREADY, 3'b010);
    step();
    m_bus.AWVALID[1] = 1'b0;
    wbeat(1, 32'h2222_0000, 1'b1);
    settle();
    chk("t2_wdata_s1", s_bus.WDATA[2], 32'h2222_0000);
    step();
    m_bus.WVALID = '0;
    sresp(2, 6'h12);
    settle();
    chk("t2_bvalid_m1", m_bus.BVALID, 3'b010);
    chk("t2_bid_m1",    m_bus.BID[1], 4'h2);
    step();
    s_bus.BVALID = '0;

    // M1 -> unmapped address, default slave answers DECERR.
    aw(1, 4'h7, 32'h3000_0000, 8'd1);
    step();
    chk("t3_awready_m", m_bus.AWREADY, 3'b010);
    chk("t3_awvalid_s", s_bus.AWVALID, 0);
    step();
    m_bus.AWVALID[1] = 1'b0;
    wbeat(1, 32'hDEAD_0000, 1'b0);
    settle();
    chk("t3_wready_b0", m_bus.WREADY, 3'b010);
    chk("t3_wvalid_s",  s_bus.WVALID, 0);
    step();
    wbeat(1, 32'hDEAD_0001, 1'b1);
    settle();
    chk("t3_wready_b1", m_bus.WREADY, 3'b010);
    step();
    m_bus.WVALID = '0; m_bus.WLAST = '0;
    settle();
    chk("t3_bvalid_m", m_bus.BVALID, 3'b010);
    chk("t3_bresp_m",  m_bus.BRESP[1], RESP_DECERR);
    chk("t3_bid_m",    m_bus.BID[1], 4'h7);
    step();
    chk("t3_done_bvalid_m", m_bus.BVALID, 0);

    // M0 -> IM and M1 -> DRAM in parallel.
    aw(0, 4'h3, 32'h0001_0040, 8'd0);
    aw(1, 4'h4, 32'h2000_0080, 8'd0);
    step();
    chk("t4_awvalid_s", s_bus.AWVALID, 6'b100010);
    chk("t4_awaddr_s1", s_bus.AWADDR[1], 32'h40);
    chk("t4_awaddr_s5", s_bus.AWADDR[5], 32'h80);
    chk("t4_awid_s5",   s_bus.AWID[5], 6'h14);
    chk("t4_awready_m", m_bus.AWREADY, 3'b011);
    step();
    m_bus.AWVALID = '0;
    wbeat(0, 32'hAAAA_0000, 1'b1);
    wbeat(1, 32'hBBBB_1111, 1'b1);
    settle();
    chk("t4_wdata_s1",  s_bus.WDATA[1], 32'hAAAA_0000);
    chk("t4_wdata_s5",  s_bus.WDATA[5], 32'hBBBB_1111);
    chk("t4_wvalid_s",  s_bus.WVALID, 6'b100010);
    chk("t4_wready_m",  m_bus.WREADY, 3'b011);
    step();
    m_bus.WVALID = '0; m_bus.WLAST = '0;
    sresp(1, 6'h03);
    sresp(5, 6'h14);
    settle();
    chk("t4_bvalid_m", m_bus.BVALID, 3'b011);
    chk("t4_bid_m0",   m_bus.BID[0], 4'h3);
    chk("t4_bid_m1",   m_bus.BID[1], 4'h4);
    step();
    s_bus.BVALID = '0;
    settle();
    chk("t4_done_bvalid_m", m_bus.BVALID, 0);

    // BREADY held low: B stays, competing M2 request waits.
    aw(0, 4'h9, 32'h0002_0000, 8'd0);
    step(); step();
    m_bus.AWVALID[0] = 1'b0;
    wbeat(0, 32'h5555_0000, 1'b1);
    step();
    m_bus.WVALID = '0; m_bus.WLAST = '0;
    m_bus.BREADY[0] = 1'b0;
    sresp(2, 6'h09);
    aw(2, 4'h6, 32'h0002_0004, 8'd3);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t5_bvalid_held", m_bus.BVALID, 3'b001);
      chk("t5_bready_s",    s_bus.BREADY, 0);
      chk("t5_no_grant",    s_bus.AWVALID, 0);
      step();
    end
    m_bus.BREADY[0] = 1'b1;
    settle();
    chk("t5_bready_s_rel", s_bus.BREADY, 6'b000100);
    step();
    s_bus.BVALID = '0;
    settle();
    chk("t5_idle_gap", s_bus.AWVALID, 0);
    step();
    chk("t5_awvalid_m2", s_bus.AWVALID, 6'b000100);
    chk("t5_awid_m2",    s_bus.AWID[2], 6'h26);
    chk("t5_awaddr_m2",  s_bus.AWADDR[2], 32'h4);

    // Reset in the middle of M2's burst.
    step();
    m_bus.AWVALID[2] = 1'b0;
    wbeat(2, 32'hCCCC_0000, 1'b0);
    settle();
    chk("t6_wvalid_s", s_bus.WVALID, 6'b000100);
    step();
    wbeat(2, 32'hCCCC_0001, 1'b0);
    ARESET = 1'b1;
    settle();
    chk("t6_rst_wvalid_s",  s_bus.WVALID, 0);
    chk("t6_rst_wready_m",  m_bus.WREADY, 0);
    chk("t6_rst_awvalid_s", s_bus.AWVALID, 0);
    chk("t6_rst_bready_s",  s_bus.BREADY, 0);
    chk("t6_rst_bvalid_m",  m_bus.BVALID, 0);
    idle_inputs();
    step();
    ARESET = 1'b0;
    aw(2, 4'h6, 32'h0002_0008, 8'd0);
    step();
    chk("t6_regrant_awvalid", s_bus.AWVALID, 6'b000100);
    chk("t6_regrant_awid",    s_bus.AWID[2], 6'h26);
    chk("t6_regrant_awaddr",  s_bus.AWADDR[2], 32'h8);
    chk("t6_regrant_awready", m_bus.AWREADY, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
